// File: rtl/jt89_pkg.sv
// Shared types for the jt89 PSG write arbiter.
// Holds the FSM state enum, the requester id and the tone-latch decode.
package jt89_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // Latch byte (bit7=1) addressing a tone register: bit4=0 selects
    // frequency, channel 3 (bits6:5=11) is the noise channel.
    function automatic logic is_tone_latch(input logic [7:0] b);
        return b[7] && !b[4] && (b[6:5] != 2'b11);
    endfunction

endpackage

// File: rtl/jt89_wrarb_fifo.sv
// Requester-B byte FIFO for the jt89 write arbiter.
// Ports: push/din in, pop/dout out, full/empty/count status.
module jt89_wrarb_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even if a pop frees a slot
    // in the same clk: acceptance follows the ready seen by the sender.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/jt89_wrarb.sv
// Two-requester write arbiter in front of a jt89 PSG bus.
// A: CPU holding register (a_wr/a_din/a_busy/a_ovf); B: sequencer FIFO
// (b_valid/b_din/b_ready); PSG side: psg_cs_n/psg_wr_n/psg_din/psg_ready.
module jt89_wrarb
    import jt89_pkg::*;
#(
    parameter int BDEPTH  = 4,
    parameter int LOCK_TO = 64,
    parameter int FAIR    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       a_wr,
    input  logic [7:0] a_din,
    output logic       a_busy,
    output logic       a_ovf,
    input  logic       b_valid,
    input  logic [7:0] b_din,
    output logic       b_ready,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    input  logic       psg_ready
);

    localparam int CW = $clog2(BDEPTH) + 1;
    localparam int FW = $clog2(FAIR + 1) + 1;
    localparam int TW = $clog2(LOCK_TO + 1);

    state_t        state_q, state_d;
    src_t          grant_q, grant_d;
    src_t          owner_q, owner_d;
    logic [7:0]    psg_din_q, psg_din_d;
    logic [7:0]    a_data_q, a_data_d;
    logic          a_busy_q, a_busy_d;
    logic          a_ovf_q, a_ovf_d;
    logic          lock_q, lock_d;
    logic [FW-1:0] fair_q, fair_d;
    logic [TW-1:0] to_q, to_d;

    logic          a_pop;
    logic          b_pop;
    logic          a_elig;
    logic          b_elig;
    logic          pick_b;
    logic [7:0]    b_dout;
    logic          b_full;
    logic          b_empty;
    logic [CW-1:0] b_count;

    jt89_wrarb_fifo #(
        .DEPTH (BDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (b_valid),
        .din   (b_din),
        .pop   (b_pop),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty),
        .count (b_count)
    );

    assign a_busy   = a_busy_q;
    assign a_ovf    = a_ovf_q;
    assign b_ready  = !b_full;
    assign psg_cs_n = (state_q != ISSUE);
    assign psg_wr_n = (state_q != ISSUE);
    assign psg_din  = psg_din_q;

    // While locked only the owner may be granted; otherwise A wins
    // unless it already took FAIR grants in a row with B waiting.
    always_comb begin
        a_elig = a_busy_q;
        b_elig = !b_empty;
        if (lock_q) begin
            a_elig = a_busy_q && (owner_q == SRC_A);
            b_elig = !b_empty && (owner_q == SRC_B);
        end
        pick_b = b_elig &&
                 (!a_elig || (!lock_q && fair_q >= FW'(FAIR)));
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        psg_din_d = psg_din_q;
        lock_d    = lock_q;
        fair_d    = fair_q;
        to_d      = to_q;
        a_pop     = 1'b0;
        b_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_elig || b_elig) begin
                    grant_d   = pick_b ? SRC_B : SRC_A;
                    psg_din_d = pick_b ? b_dout : a_data_q;
                    state_d   = ISSUE;
                    if (pick_b) begin
                        fair_d = '0;
                    end else if (!lock_q && !b_empty) begin
                        fair_d = fair_q + FW'(1);
                    end
                end else if (lock_q && clk_en) begin
                    if (to_q == TW'(LOCK_TO - 1)) begin
                        lock_d = 1'b0;
                        to_d   = '0;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
            ISSUE: begin
                a_pop   = (grant_q == SRC_A);
                b_pop   = (grant_q == SRC_B);
                // Only the owner can be granted while locked, so the
                // issued byte either releases, re-locks or sets a lock.
                lock_d  = is_tone_latch(psg_din_q);
                owner_d = grant_q;
                to_d    = '0;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (psg_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (b_count == '0) begin
            fair_d = '0;
        end
    end

    // A write landing in the clk that pops A refills the register.
    always_comb begin
        a_busy_d = a_busy_q;
        a_data_d = a_data_q;
        a_ovf_d  = a_ovf_q;
        if (a_pop) begin
            a_busy_d = 1'b0;
        end
        if (a_wr) begin
            if (!a_busy_q || a_pop) begin
                a_busy_d = 1'b1;
                a_data_d = a_din;
            end else begin
                a_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= SRC_A;
            owner_q   <= SRC_A;
            psg_din_q <= '0;
            a_data_q  <= '0;
            a_busy_q  <= 1'b0;
            a_ovf_q   <= 1'b0;
            lock_q    <= 1'b0;
            fair_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            psg_din_q <= psg_din_d;
            a_data_q  <= a_data_d;
            a_busy_q  <= a_busy_d;
            a_ovf_q   <= a_ovf_d;
            lock_q    <= lock_d;
            fair_q    <= fair_d;
            to_q      <= to_d;
        end
    end

endmodule

// File: doc/jt89_wrarb.md
JT89_WRARB -- requirements
Module: jt89_wrarb

Interface
REQ-001 SHALL have parameter BDEPTH, default 4: depth of requester-B write FIFO (power of two, 2..16).
REQ-002 SHALL have parameter LOCK_TO, default 64: clk_en ticks before a tone latch lock is released.
REQ-003 SHALL have parameter FAIR, default 2: maximum consecutive A grants while B is pending.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port clk_en  in  1  PSG master clock enable; used only for the lock timeout.
REQ-007 SHALL have port a_wr  in  1  requester A (CPU) write strobe, one clk.
REQ-008 SHALL have port a_din  in  8  requester A write byte.
REQ-009 SHALL have port a_busy  out  1  A holding register occupied; CPU wait source.
REQ-010 SHALL have port a_ovf  out  1  sticky flag: an a_wr arrived while a_busy was high.
REQ-011 SHALL have port b_valid  in  1  requester B (sequencer) byte valid.
REQ-012 SHALL have port b_din  in  8  requester B byte.
REQ-013 SHALL have port b_ready  out  1  B FIFO not full; a transfer occurs when b_valid and b_ready are both high.
REQ-014 SHALL have port psg_cs_n  out  1  PSG chip select, active low.
REQ-015 SHALL have port psg_wr_n  out  1  PSG write strobe, active low.
REQ-016 SHALL have port psg_din  out  8  PSG write byte.
REQ-017 SHALL have port psg_ready  in  1  PSG ready; falls one clk after psg_cs_n falls.

Function
REQ-018 A: a_wr with a_busy=0 SHALL load a_din into the holding register and set a_busy on the next clk; a_wr with a_busy=1 SHALL be dropped and SHALL set a_ovf.
REQ-019 B: the FIFO SHALL be first-in first-out; b_ready SHALL be 0 exactly when BDEPTH entries are held; a push and a pop in the same clk SHALL keep the occupancy unchanged.
REQ-020 The FSM SHALL have states IDLE, ISSUE, HOLD and WAIT.
REQ-021 IDLE: if a requester is eligible, the FSM SHALL latch the grant and byte into psg_din and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-022 ISSUE SHALL last exactly 1 clk with psg_cs_n=0 and psg_wr_n=0, SHALL pop the granted source (clear a_busy or pop the FIFO), then go to HOLD.
REQ-023 HOLD SHALL last 1 clk with strobes high, then go to WAIT.
REQ-024 WAIT SHALL keep strobes high until psg_ready=1, then go to IDLE; psg_ready is ignored in all other states.
REQ-025 psg_din SHALL be held stable from ISSUE through the end of WAIT.
REQ-026 Eligibility: A wins when both requesters are pending, unless A has been granted FAIR consecutive times with B pending, in which case B SHALL win. The counter SHALL clear on any B grant or when B is empty.
REQ-027 Lock set: an issued byte with bit7=1, bit4=0 and bits6:5 not equal to 11 (a tone latch) SHALL lock the grant to its source.
REQ-028 While locked, only the lock owner SHALL be eligible, and the fairness rule is suspended.
REQ-029 Lock release: the owner's next issued byte SHALL release the lock; if that byte is itself a tone latch, it SHALL re-lock.
REQ-030 Lock timeout: LOCK_TO clk_en ticks counted in IDLE without an owner byte SHALL release the lock; the counter SHALL restart on each lock set.
REQ-031 Latency: a_wr at clk N, with IDLE, unlocked and B empty, SHALL produce psg_cs_n=0 at N+2.
REQ-032 Boundary: a simultaneous a_wr while A is popped in ISSUE SHALL be accepted (not counted as overflow).
REQ-033 Boundary: a B push into a full FIFO while the FIFO is popped in the same clk SHALL be accepted only if b_ready was high.

Reset
REQ-034 rst SHALL set: state IDLE; psg_cs_n=1; psg_wr_n=1; psg_din=0; a_busy=0; a_ovf=0; FIFO empty (b_ready=1); lock cleared; fairness and timeout counters 0.
REQ-035 rst asserted mid-transaction SHALL abort it in the next clk with no further strobe, and the pending bytes SHALL be discarded.

Structure
REQ-036 Package jt89_pkg SHALL hold the FSM state enum, the source-id type (SRC_A, SRC_B) and the tone-latch decode function.
REQ-037 The FIFO SHALL be sub-module jt89_wrarb_fifo (parameter depth, push/pop/full/empty/count).

Verification
REQ-038 Single A write 0x8F with psg_ready tied to a 32-tick model -> cs_n low for 1 clk at N+2 with psg_din=0x8F; a_busy clears at ISSUE.
REQ-039 B pushes 0x9F,0xBF,0xDF,0xFF,0x80 while the PSG is busy -> b_ready low after 4 pushes; issue order equals push order.
REQ-040 B latch 0x85, then A writes 0x90 before B data 0x0C -> issue order 0x85,0x0C,0x90.
REQ-041 B latch 0xA1 with no follow-up, A 0x9F pending -> A issues only after 64 clk_en ticks.
REQ-042 A and B both continuously pending, unlocked -> grant pattern A,A,B repeating.
REQ-043 a_wr twice back-to-back while busy -> a_ovf=1, second byte never issued; rst in WAIT -> all outputs at reset values the next clk.
